// File: rtl/layer_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        STORE,
        DONE
    } state_e;

    localparam int DEF_NUM_INPUTS  = 16;
    localparam int DEF_NUM_NEURONS = 10;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_strobe_delay.sv
// Fixed-depth shift register that realigns address-side strobes with ROM read data.
module strobe_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// Control FSM for one fully-connected layer: walks the weight ROM, strobes the MAC,
// waits out its latency and writes each neuron's total to the output register file.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int MEM_LAT     = 1,
    parameter int MAC_LAT     = 2,
    parameter int ADDR_W      = 8,
    localparam int IN_W       = idx_w(NUM_INPUTS),
    localparam int NRN_W      = idx_w(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [IN_W-1:0]   input_sel,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              result_we,
    output logic [NRN_W-1:0]  result_idx
);

    localparam int DRAIN_CYC = MEM_LAT + MAC_LAT;
    localparam int DR_W      = $clog2(DRAIN_CYC + 1);
    localparam int SW        = 3 + IN_W;

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(NUM_INPUTS - 1);
    localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(NUM_NEURONS - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_CYC - 1);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    in_q, in_d;
    logic [NRN_W-1:0]   nrn_q, nrn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic [SW-1:0]      strobe_in, strobe_out;

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        nrn_d     = nrn_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        strobe_in = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    in_d    = '0;
                    nrn_d   = '0;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                strobe_in = {1'b1, (in_q == '0), (in_q == IN_LAST), in_q};
                if (in_q == IN_LAST) begin
                    in_d    = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                    // Hold on the final address so the counter never runs past the ROM.
                    if (nrn_q != NRN_LAST) begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    in_d   = in_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DR_LAST) begin
                    state_d = STORE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            STORE: begin
                if (nrn_q == NRN_LAST) begin
                    state_d = DONE;
                end else begin
                    nrn_d   = nrn_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            in_q    <= '0;
            nrn_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            nrn_q   <= nrn_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    strobe_delay #(
        .DEPTH (MEM_LAT),
        .W     (SW)
    ) u_strobe_delay (
        .clk   (clk),
        .clear (reset),
        .din   (strobe_in),
        .dout  (strobe_out)
    );

    assign {mac_valid, mac_first, mac_last, input_sel} = strobe_out;

    assign weight_addr = addr_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result_we   = (state_q == STORE);
    assign result_idx  = result_we ? nrn_q : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (MEM_LAT=1/MAC_LAT=2 and MEM_LAT=3/MAC_LAT=1)
// driving behavioural ROM and MAC models, with a scoreboard of per-neuron totals.
module tb_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1, start_a = 1'b0;
    logic       busy_a, done_a, mac_valid_a, mac_first_a, mac_last_a, result_we_a;
    logic [7:0] weight_addr_a;
    logic [1:0] input_sel_a;
    logic [0:0] result_idx_a;

    logic       reset_b = 1'b1, start_b = 1'b0;
    logic       busy_b, done_b, mac_valid_b, mac_first_b, mac_last_b, result_we_b;
    logic [7:0] weight_addr_b;
    logic [1:0] input_sel_b;
    logic [0:0] result_idx_b;

    layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .MEM_LAT(1), .MAC_LAT(2), .ADDR_W(8)
    ) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
        .weight_addr(weight_addr_a), .input_sel(input_sel_a), .mac_valid(mac_valid_a),
        .mac_first(mac_first_a), .mac_last(mac_last_a), .result_we(result_we_a),
        .result_idx(result_idx_a)
    );

    layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .MEM_LAT(3), .MAC_LAT(1), .ADDR_W(8)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
        .weight_addr(weight_addr_b), .input_sel(input_sel_b), .mac_valid(mac_valid_b),
        .mac_first(mac_first_b), .mac_last(mac_last_b), .result_we(result_we_b),
        .result_idx(result_idx_b)
    );

    // Behavioural ROM (weight = address + 1), input vector of ones, and MAC.
    int xin [NI] = '{1, 1, 1, 1};
    int romq_a = 0, acc_a = 0, mac_out_a = 0;
    int rb1 = 0, rb2 = 0, romq_b = 0, acc_b = 0, mac_out_b;

    always @(posedge clk) begin
        romq_a <= int'(weight_addr_a) + 1;
        if (mac_valid_a) acc_a <= (mac_first_a ? 0 : acc_a) + romq_a * xin[input_sel_a];
        mac_out_a <= acc_a;
        rb1    <= int'(weight_addr_b) + 1;
        rb2    <= rb1;
        romq_b <= rb2;
        if (mac_valid_b) acc_b <= (mac_first_b ? 0 : acc_b) + romq_b * xin[input_sel_b];
    end
    assign mac_out_b = acc_b;

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {busy_a, done_a, mac_valid_a, mac_first_a, mac_last_a, input_sel_a,
                    result_we_a, result_idx_a};
    assign ctl_b = {busy_b, done_b, mac_valid_b, mac_first_b, mac_last_b, input_sel_b,
                    result_we_b, result_idx_b};

    typedef struct {
        int idx;
        int total;
    } exp_t;
    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic set_start(input bit use_b, input bit v);
        if (use_b) start_b = v; else start_a = v;
    endtask

    task automatic set_reset(input bit use_b, input bit v);
        if (use_b) reset_b = v; else reset_a = v;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ctl_a !== 9'd0) begin
            miscompares++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, 9'd0);
        end
        vectors++;
        if (weight_addr_a !== 8'd0) begin
            miscompares++; $display("FAIL reset_addr_a got %0d want 0", weight_addr_a);
        end
        vectors++;
        if (ctl_b !== 9'd0) begin
            miscompares++; $display("FAIL reset_ctl_b got %b want %b", ctl_b, 9'd0);
        end
        vectors++;
        if (weight_addr_b !== 8'd0) begin
            miscompares++; $display("FAIL reset_addr_b got %0d want 0", weight_addr_b);
        end
        reset_a = 1'b0; reset_b = 1'b0;
    endtask

    // Full layer run checked cycle by cycle against the timeline derived from
    // the latency parameters, with totals checked at every result write.
    task automatic test_layer_run(input bit use_b, input int ml, input int mc,
                                  input bit repulse, input string name);
        int p, last_c, n, t, sel, tot, nwe, ndone, mout;
        bit e_valid, e_first, e_last, e_we, e_busy, e_done;
        logic [8:0] ctl, exp_ctl;
        logic [7:0] addr;
        exp_t e;
        p = NI + ml + mc + 1;
        last_c = NN * p + 1;
        nwe = 0; ndone = 0;
        for (int k = 0; k < NN; k++) begin
            tot = 0;
            for (int i = 0; i < NI; i++) tot += (k * NI + i + 1) * xin[i];
            exp_q.push_back('{k, tot});
        end
        set_start(use_b, 1'b1);
        for (int c = 1; c <= last_c + 2; c++) begin
            @(posedge clk);
            #1;
            set_start(use_b, repulse && (c == 2 || c == 6));
            ctl  = use_b ? ctl_b : ctl_a;
            addr = use_b ? weight_addr_b : weight_addr_a;
            mout = use_b ? mac_out_b : mac_out_a;
            n = (c - 1) / p;
            t = (c - 1) % p;
            e_busy  = (c <= last_c);
            e_done  = (c == last_c);
            e_valid = (c < last_c) && (t >= ml) && (t < ml + NI);
            e_first = e_valid && (t == ml);
            e_last  = e_valid && (t == ml + NI - 1);
            e_we    = (c < last_c) && (t == NI + ml + mc);
            sel     = e_valid ? t - ml : 0;
            exp_ctl = {e_busy, e_done, e_valid, e_first, e_last, 2'(sel), e_we, 1'(e_we ? n : 0)};
            vectors++;
            if (ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL %s cyc%0d ctl got %b want %b", name, c, ctl, exp_ctl);
            end
            if (c < last_c && t < NI) begin
                vectors++;
                if (addr !== 8'(n * NI + t)) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d addr got %0d want %0d", name, c, addr, n * NI + t);
                end
            end
            vectors++;
            if (addr > 8'(NI * NN - 1)) begin
                miscompares++;
                $display("FAIL %s cyc%0d addr_bound got %0d want <= %0d", name, c, addr, NI * NN - 1);
            end
            if (ctl[1]) begin
                nwe++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d extra_write got idx %0d want none", name, c, ctl[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (mout !== e.total || int'(ctl[0]) !== e.idx) begin
                        miscompares++;
                        $display("FAIL %s cyc%0d total got %0d/idx %0d want %0d/idx %0d",
                                 name, c, mout, ctl[0], e.total, e.idx);
                    end
                end
            end
            if (ctl[7]) ndone++;
        end
        vectors++;
        if (nwe !== NN || ndone !== 1) begin
            miscompares++;
            $display("FAIL %s pulse_count got we=%0d done=%0d want we=%0d done=1", name, nwe, ndone, NN);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending got %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid(input bit use_b, input int abort_c, input string name);
        int nbad;
        logic [8:0] ctl;
        logic [7:0] addr;
        set_start(use_b, 1'b1);
        for (int c = 1; c <= abort_c; c++) begin
            @(posedge clk);
            #1;
            set_start(use_b, 1'b0);
        end
        set_reset(use_b, 1'b1);
        @(posedge clk);
        #1;
        ctl  = use_b ? ctl_b : ctl_a;
        addr = use_b ? weight_addr_b : weight_addr_a;
        vectors++;
        if (ctl !== 9'd0 || addr !== 8'd0) begin
            miscompares++;
            $display("FAIL %s after_reset got ctl %b addr %0d want 0/0", name, ctl, addr);
        end
        set_reset(use_b, 1'b0);
        nbad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            ctl = use_b ? ctl_b : ctl_a;
            if (ctl[1] || ctl[7]) nbad++;
        end
        vectors++;
        if (nbad != 0) begin
            miscompares++;
            $display("FAIL %s stale_pulses got %0d want 0", name, nbad);
        end
        // start and reset together: reset must win, and start is not remembered
        set_start(use_b, 1'b1);
        set_reset(use_b, 1'b1);
        @(posedge clk);
        #1;
        set_start(use_b, 1'b0);
        set_reset(use_b, 1'b0);
        ctl = use_b ? ctl_b : ctl_a;
        vectors++;
        if (ctl[8] !== 1'b0) begin
            miscompares++; $display("FAIL %s start_with_reset busy got %b want 0", name, ctl[8]);
        end
        @(posedge clk);
        #1;
        ctl = use_b ? ctl_b : ctl_a;
        vectors++;
        if (ctl[8] !== 1'b0) begin
            miscompares++; $display("FAIL %s start_not_queued busy got %b want 0", name, ctl[8]);
        end
    endtask

    task automatic test_start_held();
        bit seen;
        seen = 1'b0;
        start_a = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done_a) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL held_done got none want pulse within 100 cycles");
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++; $display("FAIL held_idle busy got %b want 0", busy_a);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy_a !== 1'b1 || weight_addr_a !== 8'd0) begin
            miscompares++;
            $display("FAIL held_restart got busy %b addr %0d want busy 1 addr 0", busy_a, weight_addr_a);
        end
        start_a = 1'b0;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_layer_run(1'b0, 1, 2, 1'b0, "run_a");
        test_layer_run(1'b0, 1, 2, 1'b1, "start_ignored_a");
        test_reset_mid(1'b0, 6, "abort_a");
        test_layer_run(1'b0, 1, 2, 1'b0, "rerun_a");
        test_layer_run(1'b1, 3, 1, 1'b0, "run_b");
        test_reset_mid(1'b1, 5, "abort_b");
        test_layer_run(1'b1, 3, 1, 1'b0, "rerun_b");
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
